// File: rtl/pu_riscv_mmio_host_ahb3.sv
// pu_riscv_mmio_host_ahb3: AHB3-Lite slave giving a RISC-V test harness a
// TOHOST completion register, a UART TX FIFO, a STATUS register and a WDOG
// register. The watchdog is compiled in when PU_RISCV_MMIO_WATCHDOG_EN is
// defined; otherwise WDOG reads 0, writes are ignored and it never expires.
module pu_riscv_mmio_host_ahb3 #(
   parameter int          HADDR_SIZE   = 64,
   parameter int          HDATA_SIZE   = 64,
   parameter logic [63:0] BASE_ADDR    = 64'h8000_1000,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          WDOG_WIDTH   = 32,
   parameter int          WDOG_DEFAULT = 1000000
)(
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic                  HWRITE,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   output logic [HDATA_SIZE-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  done,
   output logic                  pass,
   output logic [HDATA_SIZE-2:0] code,
   output logic                  wdog_expired
);

   localparam int ALIGN = $clog2(HDATA_SIZE / 8);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [1:0] REG_TOHOST = 2'd0;
   localparam logic [1:0] REG_UART   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_WDOG   = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_ERR1, ST_ERR2} state_t;

   state_t                r_state;
   logic                  r_hreadyout, r_hresp;
   logic                  r_dpValid, r_dpWrite;
   logic [1:0]            r_dpReg;
   logic [7:0]            r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wrPtr, r_rdPtr;
   logic [LVL_W-1:0]      r_level;
   logic                  r_done, r_pass;
   logic [HDATA_SIZE-2:0] r_code;

   logic [HADDR_SIZE-1:0] w_offset;
   logic [1:0]            w_regIdx;
   logic                  w_mapped, w_capture, w_error, w_uartWrCap;
   logic                  w_push, w_pop, w_stallPush;
   logic [LVL_W-1:0]      w_levelNext;
   logic                  w_tohostWr, w_wdogWr, w_wdogFire, w_wdogExpired;
   logic [HDATA_SIZE-1:0] w_wdogRead, w_rdata;
   logic                  w_unused;

   assign w_offset    = HADDR - BASE_ADDR[HADDR_SIZE-1:0];
   assign w_regIdx    = w_offset[ALIGN+1:ALIGN];
   assign w_mapped    = (w_offset[ALIGN-1:0] == '0) && (w_offset[HADDR_SIZE-1:ALIGN+2] == '0);
   assign w_capture   = HSEL && HREADY && HTRANS[1];
   assign w_error     = !w_mapped
                        || (!HWRITE && (w_regIdx == REG_TOHOST || w_regIdx == REG_UART))
                        || (HWRITE && w_regIdx == REG_STATUS);
   assign w_uartWrCap = w_mapped && HWRITE && (w_regIdx == REG_UART);

   assign w_pop       = (r_level != '0) && tx_ready;
   assign w_stallPush = (r_state == ST_STALL) && (r_level != LVL_FULL);
   assign w_push      = w_stallPush || (r_dpValid && r_dpWrite && r_dpReg == REG_UART);
   assign w_levelNext = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
   assign w_tohostWr  = r_dpValid && r_dpWrite && (r_dpReg == REG_TOHOST);
   assign w_wdogWr    = r_dpValid && r_dpWrite && (r_dpReg == REG_WDOG);

   // Data-phase FSM: decides the response at address capture so HREADYOUT/HRESP come straight from flops
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= ST_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
         r_dpValid   <= 1'b0;
         r_dpWrite   <= 1'b0;
         r_dpReg     <= REG_TOHOST;
      end else begin
         r_dpValid <= 1'b0;
         case (r_state)
            ST_IDLE, ST_ERR2: begin
               if (w_capture && w_error) begin
                  r_state     <= ST_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= 1'b1;
               end else if (w_capture && w_uartWrCap && w_levelNext == LVL_FULL) begin
                  r_state     <= ST_STALL;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= 1'b0;
               end else begin
                  r_state     <= ST_IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= 1'b0;
                  r_dpValid   <= w_capture;
                  r_dpWrite   <= HWRITE;
                  r_dpReg     <= w_regIdx;
               end
            end
            ST_STALL: begin
               if (w_stallPush) begin
                  r_state     <= ST_IDLE;
                  r_hreadyout <= 1'b1;
               end
            end
            ST_ERR1: begin
               r_state     <= ST_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= 1'b0;
            end
         endcase
      end
   end

   // FIFO storage is not reset; tx_data is masked while the FIFO is empty
   always_ff @(posedge HCLK) begin
      if (w_push) r_mem[r_wrPtr] <= HWDATA[7:0];
   end

   // FIFO pointers wrap naturally because the depth is a power of two
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         r_level <= w_levelNext;
      end
   end

   // Sticky test result; a watchdog timeout overrides a same-cycle TOHOST write
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
         r_code <= '0;
      end else if (w_wdogFire) begin
         r_done <= 1'b1;
         r_pass <= 1'b0;
         r_code <= '0;
      end else if (w_tohostWr && HWDATA[0] && !r_done) begin
         r_done <= 1'b1;
         r_pass <= (HWDATA == HDATA_SIZE'(1));
         r_code <= HWDATA[HDATA_SIZE-1:1];
      end
   end

`ifdef PU_RISCV_MMIO_WATCHDOG_EN
   logic [WDOG_WIDTH-1:0] r_wdCount, r_wdReload;
   logic                  r_wdExpired;

   assign w_wdogFire    = !r_done && !w_wdogWr && (r_wdCount <= WDOG_WIDTH'(1));
   assign w_wdogExpired = r_wdExpired;
   assign w_wdogRead    = HDATA_SIZE'(r_wdCount);
   assign w_unused      = ^{HMASTLOCK, HBURST, HPROT, HSIZE, r_wdReload};

   // Watchdog counts down while the test runs; a WDOG write reloads it, reaching zero ends the test
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wdCount   <= WDOG_WIDTH'(WDOG_DEFAULT);
         r_wdReload  <= WDOG_WIDTH'(WDOG_DEFAULT);
         r_wdExpired <= 1'b0;
      end else if (w_wdogWr) begin
         r_wdCount  <= HWDATA[WDOG_WIDTH-1:0];
         r_wdReload <= HWDATA[WDOG_WIDTH-1:0];
      end else if (w_wdogFire) begin
         r_wdCount   <= '0;
         r_wdExpired <= 1'b1;
      end else if (!r_done) begin
         r_wdCount <= r_wdCount - WDOG_WIDTH'(1);
      end
   end
`else
   assign w_wdogFire    = 1'b0;
   assign w_wdogExpired = 1'b0;
   assign w_wdogRead    = '0;
   assign w_unused      = ^{HMASTLOCK, HBURST, HPROT, HSIZE, w_wdogWr};
`endif

   // Read data is driven only during the data phase of an accepted read
   always_comb begin
      w_rdata = '0;
      if (r_dpValid && !r_dpWrite) begin
         if (r_dpReg == REG_STATUS) begin
            w_rdata[0]    = (r_level == LVL_FULL);
            w_rdata[1]    = (r_level == '0);
            w_rdata[2]    = r_done;
            w_rdata[3]    = r_pass;
            w_rdata[4]    = w_wdogExpired;
            w_rdata[15:8] = 8'(r_level);
         end else if (r_dpReg == REG_WDOG) begin
            w_rdata = w_wdogRead;
         end
      end
   end

   assign HRDATA       = w_rdata;
   assign HREADYOUT    = r_hreadyout;
   assign HRESP        = r_hresp;
   assign tx_valid     = (r_level != '0);
   assign tx_data      = (r_level != '0) ? r_mem[r_rdPtr] : 8'h00;
   assign done         = r_done;
   assign pass         = r_pass;
   assign code         = r_code;
   assign wdog_expired = w_wdogExpired;

endmodule
